// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined WIDTH-bit add/subtract unit with valid/ready handshake
//
// Purpose:
//   Computes A + (sub ? ~B : B) + (cin ^ sub) over STAGES = WIDTH/CHUNK register
//   stages. Each stage ripples one CHUNK-bit slice and hands its carry to the next.
//   The flags are produced in the last stage.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid/in_ready - operand handshake (in_ready depends only on out_valid/out_ready)
//   A, B, cin, sub    - operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid/out_ready - result handshake
//   Result            - WIDTH-bit sum/difference (mod 2^WIDTH)
//   CarryOut          - raw carry out of the MSB (in subtract mode 1 = no borrow)
//   Overflow          - signed overflow (carry into MSB xor carry out of MSB)
//   Zero, Negative    - Result == 0, Result[WIDTH-1]
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             Negative
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             advance;
  logic [WIDTH-1:0] b_cond;

  // The stall is global: either the whole pipe moves or the whole pipe holds.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_cond   = sub ? ~B : B;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    // PEND: operand bits not yet summed when this slice starts, including its own chunk.
    // DONE: sum bits that are complete once this slice has run.
    localparam int PEND = WIDTH - k * CHUNK;
    localparam int DONE = (k + 1) * CHUNK;

    logic [PEND-1:0]  a_in;
    logic [PEND-1:0]  b_in;
    logic             c_in;
    logic             v_in;
    logic [CHUNK:0]   part;
    logic [DONE-1:0]  s_next;

    if (k == 0) begin : g_first
      assign a_in   = A;
      assign b_in   = b_cond;
      assign c_in   = cin ^ sub;
      assign v_in   = in_valid;
      assign s_next = part[CHUNK-1:0];
    end else begin : g_next
      assign a_in   = g_slice[k-1].g_mid.a_q;
      assign b_in   = g_slice[k-1].g_mid.b_q;
      assign c_in   = g_slice[k-1].g_mid.c_q;
      assign v_in   = g_slice[k-1].g_mid.v_q;
      assign s_next = {part[CHUNK-1:0], g_slice[k-1].g_mid.s_q};
    end

    assign part = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

    if (k < STAGES - 1) begin : g_mid
      logic                  v_q;
      logic                  c_q;
      logic [DONE-1:0]       s_q;
      logic [PEND-CHUNK-1:0] a_q;
      logic [PEND-CHUNK-1:0] b_q;

      // Data in an empty stage is don't-care, so intermediate stages load on every advance.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          s_q <= '0;
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          v_q <= v_in;
          c_q <= part[CHUNK];
          s_q <= s_next;
          a_q <= a_in[PEND-1:CHUNK];
          b_q <= b_in[PEND-1:CHUNK];
        end
      end
    end else begin : g_last
      logic msb_carry_in;

      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
      assign msb_carry_in = part[CHUNK-1] ^ a_in[CHUNK-1] ^ b_in[CHUNK-1];

      // Result and flags only load for a real token so they hold while out_valid = 0.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          Result    <= '0;
          CarryOut  <= 1'b0;
          Overflow  <= 1'b0;
          Zero      <= 1'b1;
          Negative  <= 1'b0;
        end else if (advance) begin
          out_valid <= v_in;
          if (v_in) begin
            Result   <= s_next;
            CarryOut <= part[CHUNK];
            Overflow <= msb_carry_in ^ part[CHUNK];
            Zero     <= ~|s_next;
            Negative <= s_next[WIDTH-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub (WIDTH=16, CHUNK=4)
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Result;
  logic        CarryOut;
  logic        Overflow;
  logic        Zero;
  logic        Negative;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  logic [19:0] exp_q[$];
  logic        held_valid;
  logic [19:0] held;

  // Directed vectors; expected = {CarryOut, Overflow, Zero, Negative, Result}.
  localparam int ND = 8;
  localparam logic [15:0] DA [ND] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h1000,
                                      16'h0000, 16'h8000, 16'h1234, 16'h8000};
  localparam logic [15:0] DB [ND] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001,
                                      16'h0000, 16'h0001, 16'h4321, 16'h8000};
  localparam logic        DC [ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic        DS [ND] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [19:0] DE [ND] = '{20'hA0000, 20'h58000, 20'h1FFFE, 20'h80FFE,
                                      20'hA0000, 20'hC7FFF, 20'h05556, 20'hE0000};

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .CarryOut  (CarryOut),
    .Overflow  (Overflow),
    .Zero      (Zero),
    .Negative  (Negative)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sb);
    logic [15:0] bc;
    logic [16:0] s;
    logic        v;
    bc = sb ? ~b : b;
    s  = {1'b0, a} + {1'b0, bc} + {16'h0, ci ^ sb};
    v  = (a[15] == bc[15]) && (s[15] != a[15]);
    return {s[16], v, s[15:0] == 16'h0, s[15], s[15:0]};
  endfunction

  function automatic logic [19:0] obs();
    return {CarryOut, Overflow, Zero, Negative, Result};
  endfunction

  // One clock: drive at edge+1, evaluate handshakes at edge+2, advance to next edge+1.
  task automatic cycle(input logic iv, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb, input logic ordy,
                       input logic hand, input logic [19:0] hexp, output logic acc);
    in_valid  = iv;
    A         = a;
    B         = b;
    cin       = ci;
    sub       = sb;
    out_ready = ordy;
    #1;
    if (held_valid) check("stall_hold", obs(), held);
    held_valid = 1'b0;
    if (out_valid && !out_ready) begin
      check("stall_in_ready", in_ready, 0);
      held_valid = 1'b1;
      held       = obs();
      stall_cnt++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", 1, 0);
      else check("result", obs(), exp_q.pop_front());
    end
    acc = iv && in_ready;
    if (acc) exp_q.push_back(hand ? hexp : model(a, b, ci, sb));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h0, acc);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic        acc;
    int          n;
    int          cnt;
    int          i;
    int          cyc;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1; held_valid = 1'b0; held = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", Result, 0);
    check("rst_zero", Zero, 1);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Latency of a single op, counting the transfer edge.
    cycle(1'b1, DA[0], DB[0], DC[0], DS[0], 1'b1, 1'b1, DE[0], acc);
    check("lat_accept", acc, 1);
    n = 1;
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, 4);
    drain();

    // Directed vectors, back to back.
    for (int k = 0; k < ND; k++) begin
      cycle(1'b1, DA[k], DB[k], DC[k], DS[k], 1'b1, 1'b1, DE[k], acc);
      check("dir_accept", acc, 1);
    end
    drain();

    // Reset with ops in flight and a valid result on the output.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 16'h1111 * k[15:0] + 16'h1, 16'h0101, 1'b0, 1'b0, 1'b1, 1'b0, 20'h0, acc);
    end
    check("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", Result, 0);
    check("mid_rst_zero", Zero, 1);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    held_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) cnt++;
      @(posedge clk);
      #1;
    end
    check("rst_ghost_outputs", cnt, 0);

    // Backpressure: 8 ops with out_ready low for 5 cycles mid-stream.
    stall_cnt = 0;
    i = 0;
    cyc = 0;
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
    while ((i < 8 || exp_q.size() != 0) && cyc < 100) begin
      if (i < 8) begin
        cycle(1'b1, ra, rb, rc, rs, !(cyc >= 5 && cyc < 10), 1'b0, 20'h0, acc);
        if (acc) begin
          i++;
          ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        end
      end else begin
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, !(cyc >= 5 && cyc < 10), 1'b0, 20'h0, acc);
      end
      cyc++;
    end
    check("bp_accepted", i, 8);
    check("bp_drained", exp_q.size(), 0);
    check("bp_stall_cycles", stall_cnt, 5);

    // Random regression.
    for (int k = 0; k < 10000; k++) begin
      cycle(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            ($urandom % 4) != 0, 1'b0, 20'h0, acc);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined add/subtract unit for the ALU datapath. It generalises the 4-bit ripple adder to WIDTH bits, split into CHUNK-bit ripple slices, one register stage per slice. It adds a subtract mode, carry/borrow chaining, status flags, and a valid/ready handshake with backpressure. It sits between the operand-select logic and the ALU result mux, and accepts one operation per cycle when not stalled.

## Interface
- WIDTH, default 16: operand and result width; must be a multiple of CHUNK, ≥ CHUNK.
- CHUNK, default 4: bits per pipeline slice; STAGES = WIDTH/CHUNK.
- clk  input  1: clock; all state changes on rising edge.
- rst  input  1: asynchronous, active-high reset.
- in_valid  input  1: operands presented this cycle.
- in_ready  output  1: unit accepts operands this cycle.
- A  input  WIDTH: operand A.
- B  input  WIDTH: operand B.
- cin  input  1: carry-in (add), borrow-in (sub).
- sub  input  1: 0 = add, 1 = subtract.
- out_valid  output  1: Result and flags valid.
- out_ready  input  1: downstream consumes result this cycle.
- Result  output  WIDTH: sum or difference, modulo 2^WIDTH.
- CarryOut  output  1: carry out of MSB. In sub mode, 1 = no borrow.
- Overflow  output  1: signed two's-complement overflow.
- Zero  output  1: Result == 0.
- Negative  output  1: Result[WIDTH-1].

## Operation
- Arithmetic: Result = A + (sub ? ~B : B) + (cin ^ sub), full WIDTH+1-bit sum.
  - add: A+B+cin.
  - sub: A−B−cin.
- CarryOut is the raw carry out of the MSB; no inversion in sub mode.
- Overflow = carry into MSB XOR carry out of MSB.
- Zero and Negative are computed from the final Result.
- Slice k (k = 0..STAGES−1):
  - Adds chunk k of A and the conditioned B, using the carry registered from slice k−1. Slice 0 uses cin^sub.
  - Registers the chunk-k sum, the carry out, and the flag inputs it needs.
- Operand skew:
  - Upper chunks of A, conditioned B, and sub travel with the token.
  - Completed lower chunks of the sum travel with the token.
  - Each token occupies exactly one stage.
- Each stage holds one valid bit. Valid bits shift together with data.
- Handshake: advance = !out_valid || out_ready.
  - in_ready = advance.
  - When advance = 1, every stage loads from its predecessor; stage 0 loads {in_valid, operands}.
  - When advance = 0, all stages hold.
  - Stall is global; bubbles are not collapsed.
- A transfer occurs at the input when in_valid && in_ready, and at the output when out_valid && out_ready.
- Reset (async, any time, including mid-pipeline):
  - All valid bits, Result, CarryOut, Overflow, and Negative clear to 0. Zero clears to 1, consistent with Result = 0.
  - In-flight operations are discarded.
  - in_ready = 1 immediately after reset.
- Data in stages with valid = 0 is don't-care internally. Result and flag outputs hold their last registered values when out_valid = 0.

## Timing
- Latency: STAGES cycles from the input transfer edge to out_valid = 1 (4 for the defaults).
- Throughput: one operation per cycle while out_ready = 1.
- Critical path: one CHUNK-bit ripple plus flag logic in the last stage.
- Under stall, Result and flags stay stable while out_valid = 1 && out_ready = 0.
- in_ready is combinational from out_valid and out_ready only. There is no path from in_valid to in_ready.
- Simultaneous out and in transfers in the same cycle are legal and lossless with a full pipeline.
- Wrap-around: the sum is truncated to WIDTH bits; the overflow bit is reported only on CarryOut.

## Test plan
All cases use WIDTH=16, CHUNK=4.
- Reset: assert rst mid-stream with 3 ops in flight → out_valid = 0 and Result = 0x0000 with no clock edge. After release, the in-flight ops never appear.
- Add carry chain: A=0xFFFF, B=0x0001, cin=0, sub=0 → after 4 cycles Result=0x0000, CarryOut=1, Zero=1, Overflow=0, Negative=0.
- Signed overflow: A=0x7FFF, B=0x0001, add → Result=0x8000, Overflow=1, Negative=1, CarryOut=0.
- Subtract with borrow: A=0x0005, B=0x0007, sub=1, cin=0 → Result=0xFFFE, CarryOut=0, Negative=1. Then A=0x1000, B=0x0001, sub=1, cin=1 → Result=0x0FFE, CarryOut=1.
- Backpressure: stream 8 back-to-back ops with random operands, hold out_ready = 0 for 5 cycles mid-stream → in_ready drops the same cycle and outputs hold stable. All 8 results appear in order with no loss or duplication.
- Random regression: 10k random A/B/cin/sub with random out_ready and in_valid → scoreboard matches the reference equation and flags; order preserved.
